// File: rtl/sm_1118_xbee_msg_queue.sv
// sm_1118_xbee_msg_queue
//   Message request queue that feeds the XBee UART transmitter. It buffers
//   supply-identification / pick / deposit requests and hands them to the
//   transmitter one frame at a time. Each frame is held until the transmitter
//   reports completion, and frames are separated by an idle gap. A watchdog
//   aborts any frame the transmitter never finishes.
//
// Ports
//   clk_50M, reset          : clock, asynchronous active-high reset
//   req_valid/req_ready     : request handshake (req_ready is registered)
//   req_type/field/node/color : request contents (type 0 is illegal, dropped)
//   err_clr                 : clears the sticky error flags
//   tx_complete             : one-cycle end-of-frame pulse from transmitter
//   tx_start                : level request to transmitter, high per frame
//   msg_type/field/node_si/color : message fields, stable from LOAD onward
//   busy                    : high while a frame is loading, sending or gapping
//   count                   : FIFO occupancy
//   drop_err, timeout_err   : sticky error flags
module sm_1118_xbee_msg_queue #(
  parameter int DEPTH   = 4,
  parameter int GAP     = 434,
  parameter int TIMEOUT = 100000
) (
  input  logic                     clk_50M,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_type,
  input  logic [1:0]               req_field,
  input  logic [1:0]               req_node,
  input  logic [1:0]               req_color,
  input  logic                     err_clr,
  input  logic                     tx_complete,
  output logic                     tx_start,
  output logic [1:0]               msg_type,
  output logic [1:0]               field,
  output logic [1:0]               node_si,
  output logic [1:0]               color,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int WW = 17;

  localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DEPTH);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [WW-1:0] TO_LAST  = WW'(TIMEOUT - 1);

  typedef struct packed {
    logic [1:0] typ;
    logic [1:0] fld;
    logic [1:0] node;
    logic [1:0] clr;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count_next;
  state_t          state;
  logic [WW-1:0]   wd;
  logic [GW-1:0]   gap_cnt;
  logic            accept, push, pop, drop_set, to_fire;

  // An illegal-type request still completes the handshake; it just never
  // reaches the storage.
  assign accept   = req_valid & req_ready;
  assign push     = accept & (req_type != 2'd0);
  assign drop_set = accept & (req_type == 2'd0);
  assign pop      = (state == S_IDLE) & (count != '0);
  assign head     = mem[rptr];

  // Completion has priority over the watchdog in the same cycle.
  assign to_fire  = (state == S_SEND) & ~tx_complete & (wd == TO_LAST);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk_50M) begin
    if (push)
      mem[wptr] <= {req_type, req_field, req_node, req_color};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      req_ready <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count     <= count_next;
      // Registered, so a full queue stays not-ready for the cycle in which
      // it is popped.
      req_ready <= (count_next < DEPTH_V);
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      msg_type <= 2'd0;
      field    <= 2'd0;
      node_si  <= 2'd0;
      color    <= 2'd0;
      wd       <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            msg_type <= head.typ;
            field    <= head.fld;
            node_si  <= head.node;
            color    <= head.clr;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Fields have been stable for a full cycle before tx_start rises.
          tx_start <= 1'b1;
          wd       <= '0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (tx_complete || (wd == TO_LAST)) begin
            tx_start <= 1'b0;
            gap_cnt  <= '0;
            state    <= S_GAP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      drop_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      drop_err    <= drop_set | (drop_err & ~err_clr);
      timeout_err <= to_fire  | (timeout_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_sm_1118_xbee_msg_queue.sv
module tb_sm_1118_xbee_msg_queue;
  localparam int DEPTH   = 4;
  localparam int GAP     = 434;
  localparam int TIMEOUT = 100;

  logic       clk_50M = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0, err_clr = 1'b0, tx_complete = 1'b0;
  logic [1:0] req_type = '0, req_field = '0, req_node = '0, req_color = '0;
  logic       req_ready, tx_start, busy, drop_err, timeout_err;
  logic [1:0] msg_type, field, node_si, color;
  logic [$clog2(DEPTH):0] count;

  int tests = 0, fails = 0;
  int cyc = 0, frames = 0, rise_cyc = 0, fall_cyc = -100000;
  logic prev_tx = 1'b0;
  logic [7:0] mon_e;
  logic [7:0] exp_q[$];   // legal accepted requests, in expected frame order

  sm_1118_xbee_msg_queue #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk_50M(clk_50M), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_field(req_field), .req_node(req_node), .req_color(req_color),
    .err_clr(err_clr), .tx_complete(tx_complete), .tx_start(tx_start),
    .msg_type(msg_type), .field(field), .node_si(node_si), .color(color),
    .busy(busy), .count(count), .drop_err(drop_err), .timeout_err(timeout_err)
  );

  always #5 clk_50M = ~clk_50M;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame monitor: fields in queue order, inter-frame gap, frame length.
  initial forever begin
    @(negedge clk_50M);
    cyc++;
    if (reset) begin
      prev_tx  = 1'b0;
      fall_cyc = -100000;
    end else begin
      if (tx_start && !prev_tx) begin
        frames++;
        rise_cyc = cyc;
        chk("frame_gap", 32'(cyc - fall_cyc >= GAP + 2), 1);
        chk("frame_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("frame_fields", {msg_type, field, node_si, color}, mon_e);
        end
      end
      if (!tx_start && prev_tx) begin
        fall_cyc = cyc;
        chk("frame_len", 32'(cyc - rise_cyc <= TIMEOUT), 1);
      end
      prev_tx = tx_start;
    end
  end

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic offer(input logic [1:0] t, input logic [1:0] f, input logic [1:0] n,
                       input logic [1:0] c, input logic acc);
    req_valid = 1'b1; req_type = t; req_field = f; req_node = n; req_color = c;
    chk("req_ready", req_ready, acc);
    if (acc && t != 2'd0) exp_q.push_back({t, f, n, c});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic offer_rnd(input logic acc);
    offer(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
          2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)), acc);
  endtask

  task automatic wait_tx_high(input string tag);
    int n = 0;
    while (tx_start !== 1'b1 && n < 1000) begin tick(); n++; end
    chk(tag, tx_start, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin tick(); n++; end
    chk(tag, busy, 0);
  endtask

  task automatic send_frame(input int hold);
    wait_tx_high("frame_rise");
    repeat (hold) tick();
    tx_complete = 1'b1;
    tick();
    tx_complete = 1'b0;
    chk("frame_release", tx_start, 0);
  endtask

  initial begin
    int hi, f0;

    // Reset state
    repeat (2) tick();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_errs", {drop_err, timeout_err}, 0);
    chk("rst_fields", {msg_type, field, node_si, color}, 0);
    reset = 1'b0;
    chk("ready_before_edge", req_ready, 0);
    tick();
    chk("ready_after_rst", req_ready, 1);

    // Single SI request: latency, fields, release, gap
    offer(2'd1, 2'd3, 2'd1, 2'd2, 1'b1);
    chk("si_count", count, 1);
    chk("si_busy_n", busy, 0);
    tick();
    chk("si_load_tx", tx_start, 0);
    chk("si_load_busy", busy, 1);
    chk("si_load_count", count, 0);
    tick();
    chk("si_tx_start", tx_start, 1);
    chk("si_fields", {msg_type, field, node_si, color}, 8'b01_11_01_10);
    repeat (48) tick();
    tx_complete = 1'b1;
    tick();
    tx_complete = 1'b0;
    chk("si_release", tx_start, 0);
    chk("si_gap_busy", busy, 1);
    repeat (GAP - 1) tick();
    chk("si_gap_last", busy, 1);
    tick();
    chk("si_gap_done", busy, 0);
    chk("si_no_timeout", timeout_err, 0);

    // Backpressure: six back-to-back offers, the sixth refused
    for (int i = 0; i < 6; i++) offer_rnd(i < 5);
    chk("bp_full_count", count, DEPTH);
    chk("bp_full_ready", req_ready, 0);
    for (int i = 0; i < 5; i++) send_frame($urandom_range(0, 80));
    wait_idle("bp_idle");
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_count", count, 0);

    // Illegal type between two legal requests
    f0 = frames;
    offer_rnd(1'b1);
    wait_tx_high("il_first_rise");
    offer_rnd(1'b1);
    chk("il_count_a", count, 1);
    offer(2'd0, 2'd1, 2'd2, 2'd3, 1'b1);
    chk("il_drop_set", drop_err, 1);
    chk("il_count_same", count, 1);
    offer_rnd(1'b1);
    chk("il_count_b", count, 2);
    err_clr = 1'b1;
    offer(2'd0, 2'd0, 2'd1, 2'd1, 1'b1);
    err_clr = 1'b0;
    chk("il_set_wins", drop_err, 1);
    for (int i = 0; i < 3; i++) send_frame($urandom_range(0, 80));
    wait_idle("il_idle");
    chk("il_frames", frames - f0, 3);
    chk("il_drained", exp_q.size(), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("il_clr", drop_err, 0);

    // Watchdog expiry, next entry still sent after the gap
    offer_rnd(1'b1);
    offer_rnd(1'b1);
    wait_tx_high("to_rise");
    hi = 1;
    while (tx_start === 1'b1 && hi < 300) begin
      tick();
      if (tx_start === 1'b1) hi++;
    end
    chk("to_high_len", hi, TIMEOUT);
    chk("to_err", timeout_err, 1);
    send_frame($urandom_range(0, 80));
    wait_idle("to_idle");
    chk("to_drained", exp_q.size(), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clr", timeout_err, 0);

    // Completion on the watchdog's last cycle wins
    offer_rnd(1'b1);
    wait_tx_high("sc_rise");
    repeat (TIMEOUT - 1) tick();
    chk("sc_still_high", tx_start, 1);
    tx_complete = 1'b1;
    tick();
    tx_complete = 1'b0;
    chk("sc_release", tx_start, 0);
    chk("sc_no_err", timeout_err, 0);
    wait_idle("sc_idle");

    // Reset mid-SEND with three queued, then a stray completion in IDLE
    for (int i = 0; i < 4; i++) offer_rnd(1'b1);
    chk("rs_count", count, 3);
    chk("rs_sending", tx_start, 1);
    reset = 1'b1;
    #1;
    chk("rs_tx_start", tx_start, 0);
    chk("rs_count0", count, 0);
    chk("rs_busy", busy, 0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    chk("rs_ready", req_ready, 1);
    repeat (5) tick();
    tx_complete = 1'b1;
    tick();
    tx_complete = 1'b0;
    chk("stray_busy", busy, 0);
    f0 = frames;
    repeat (600) tick();
    chk("rs_no_frame", frames - f0, 0);
    chk("rs_tx_low", tx_start, 0);
    chk("rs_errs", {drop_err, timeout_err}, 0);

    // Queue still works after reset
    offer_rnd(1'b1);
    send_frame(10);
    wait_idle("post_idle");
    chk("post_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
